operand_fetch: RTL

- Upstream stage of the node ALU. Resolves the source operand of ADD/SUB/MOV-type instructions into the 11-bit signed `arg1` consumed by the add/sub units (`acc`, `arg1` → `out`).
- Sources: immediate, ACC, NIL, one of four neighbour ports (LEFT/RIGHT/UP/DOWN), ANY, or LAST.
- Port reads block on a valid/ack handshake with the neighbour node.
- All delivered values lie in the node range -999..999.

---
 rtl/sincere_pkg.sv | 42 ++++
 rtl/sat_clamp.sv | 22 ++
 rtl/operand_fetch.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/sincere_pkg.sv
// Shared definitions for the node ALU front end: operand width and range,
// source-select codes, port indices and the operand-fetch state encoding.
package sincere_pkg;

  localparam int unsigned WIDTH    = 11;
  localparam int          MAXV     = 999;
  localparam int unsigned NumPorts = 4;

  typedef enum logic [3:0] {
    SrcImm   = 4'd0,
    SrcAcc   = 4'd1,
    SrcNil   = 4'd2,
    SrcLeft  = 4'd3,
    SrcRight = 4'd4,
    SrcUp    = 4'd5,
    SrcDown  = 4'd6,
    SrcAny   = 4'd7,
    SrcLast  = 4'd8
  } src_e;

  localparam logic [1:0] PortLeft  = 2'd0;
  localparam logic [1:0] PortRight = 2'd1;
  localparam logic [1:0] PortUp    = 2'd2;
  localparam logic [1:0] PortDown  = 2'd3;

  // LAST register: bit 2 set means no port has been recorded yet.
  localparam logic [2:0] LastNone = 3'b100;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StDone = 2'd2
  } state_e;

  // Maps a direct port source code (LEFT..DOWN) onto its port index.
  function automatic logic [1:0] src_port(input logic [3:0] src);
    logic [3:0] idx;
    idx = src - 4'd3;
    return idx[1:0];
  endfunction

endpackage

// File: rtl/sat_clamp.sv
// Combinational saturation of a two's complement value into [-Maxv, Maxv].
module sat_clamp #(
  parameter int unsigned Width = 11,
  parameter int          Maxv  = 999
) (
  input  logic [Width-1:0] in_i,
  output logic [Width-1:0] out_o
);

  localparam logic signed [Width-1:0] PosLim = Width'(Maxv);
  localparam logic signed [Width-1:0] NegLim = Width'(-Maxv);

  always_comb begin
    out_o = in_i;
    if ($signed(in_i) > PosLim) begin
      out_o = PosLim;
    end else if ($signed(in_i) < NegLim) begin
      out_o = NegLim;
    end
  end

endmodule

// File: rtl/operand_fetch.sv
// Resolves the ALU source operand (immediate, ACC, NIL, neighbour port, ANY, LAST)
// into a clamped arg1 with a one-cycle valid pulse; port reads block on valid/ack.
module operand_fetch
  import sincere_pkg::*;
#(
  parameter int unsigned Width = WIDTH,
  parameter int          Maxv  = MAXV
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      fetch_valid_i,
  output logic                      fetch_ready_o,
  input  logic [3:0]                src_sel_i,
  input  logic [Width-1:0]          imm_i,
  input  logic [Width-1:0]          acc_i,
  input  logic [NumPorts*Width-1:0] port_data_i,
  input  logic [NumPorts-1:0]       port_valid_i,
  output logic [NumPorts-1:0]       port_ack_o,
  output logic [Width-1:0]          arg1_o,
  output logic                      arg1_valid_o,
  output logic                      busy_o
);

  state_e                state_q;
  logic [1:0]            sel_q;
  logic                  any_q;
  logic [2:0]            last_q;
  logic [Width-1:0]      arg1_q;
  logic                  arg1_valid_q;
  logic [NumPorts-1:0]   ack_q;

  logic [Width-1:0]      port_word [NumPorts];
  logic                  hit;
  logic [1:0]            hit_idx;
  logic [Width-1:0]      clamp_in;
  logic [Width-1:0]      clamp_out;

  always_comb begin
    for (int p = 0; p < int'(NumPorts); p++) begin
      port_word[p] = port_data_i[p*Width +: Width];
    end
  end

  // ANY re-arbitrates every WAIT cycle; scanning downwards leaves LEFT as the winner.
  always_comb begin
    hit     = 1'b0;
    hit_idx = sel_q;
    if (any_q) begin
      for (int p = int'(NumPorts) - 1; p >= 0; p--) begin
        if (port_valid_i[p]) begin
          hit     = 1'b1;
          hit_idx = 2'(p);
        end
      end
    end else begin
      hit = port_valid_i[sel_q];
    end
  end

  // One clamp serves both paths: request operands in IDLE, port data in WAIT.
  always_comb begin
    clamp_in = imm_i;
    if (state_q == StWait) begin
      clamp_in = port_word[hit_idx];
    end else if (src_sel_i == SrcAcc) begin
      clamp_in = acc_i;
    end
  end

  sat_clamp #(
    .Width (Width),
    .Maxv  (Maxv)
  ) u_clamp (
    .in_i  (clamp_in),
    .out_o (clamp_out)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      sel_q        <= PortLeft;
      any_q        <= 1'b0;
      last_q       <= LastNone;
      arg1_q       <= '0;
      arg1_valid_q <= 1'b0;
      ack_q        <= '0;
    end else begin
      arg1_valid_q <= 1'b0;
      ack_q        <= '0;
      case (state_q)
        StIdle: begin
          if (fetch_valid_i) begin
            case (src_e'(src_sel_i))
              SrcImm, SrcAcc: begin
                arg1_q       <= clamp_out;
                arg1_valid_q <= 1'b1;
                state_q      <= StDone;
              end
              SrcLeft, SrcRight, SrcUp, SrcDown: begin
                sel_q   <= src_port(src_sel_i);
                any_q   <= 1'b0;
                state_q <= StWait;
              end
              SrcAny: begin
                any_q   <= 1'b1;
                state_q <= StWait;
              end
              SrcLast: begin
                if (last_q != LastNone) begin
                  sel_q   <= last_q[1:0];
                  any_q   <= 1'b0;
                  state_q <= StWait;
                end else begin
                  arg1_q       <= '0;
                  arg1_valid_q <= 1'b1;
                  state_q      <= StDone;
                end
              end
              default: begin
                arg1_q       <= '0;
                arg1_valid_q <= 1'b1;
                state_q      <= StDone;
              end
            endcase
          end
        end
        StWait: begin
          if (hit) begin
            arg1_q       <= clamp_out;
            arg1_valid_q <= 1'b1;
            ack_q        <= NumPorts'(1) << hit_idx;
            state_q      <= StDone;
            if (any_q) begin
              last_q <= {1'b0, hit_idx};
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign fetch_ready_o = (state_q == StIdle);
  assign busy_o        = (state_q == StWait);
  assign port_ack_o    = ack_q;
  assign arg1_o        = arg1_q;
  assign arg1_valid_o  = arg1_valid_q;

endmodule
